mult16_serial_ctrl: RTL
=======================

// Module: mult16_serial_ctrl
// PURPOSE
//  Operand sequencer and product collector wrapped around the 16-bit serial shift-add multiplier core.
//  - Accepts a parallel operand pair over a valid/ready handshake.
//  - Drives the core: 16 parallel multiplicand bits, plus 1 serial multiplier bit per cycle, LSB first.
//  - Deserialises the core's LSB-first serial product bit into a 32-bit result.
//  - The core has no reset or clear, so this block owns zero-flushing its state.
// PARAMETERS
//  WIDTH        16  operand width; core is fixed at 16, other values unsupported
//  INIT_CYCLES  32  zero-drive cycles after reset to purge core state (must be >= 2*WIDTH)
// PORTS
//  clock        in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  in_valid     in   1   operand pair valid
//  in_ready     out  1   block accepts operands (IDLE only)
//  in_a         in   16  multiplicand
//  in_b         in   16  multiplier
//  mc_bits      out  16  to core multiplicand inputs (p_3 = bit0 .. p_18 = bit15)
//  mb_bit       out  1   to core serial multiplier input (p_1)
//  prod_bit     in   1   from core serial product output (p_36), combinational in the core
//  out_valid    out  1   product valid
//  out_ready    in   1   consumer accepts product
//  out_product  out  32  a*b, unsigned
//  busy         out  1   high in INIT and RUN
// BEHAVIOUR
//  - Reset (asynchronous, active-high)
//    - Forces state INIT and count=0.
//    - Forces in_ready=0, out_valid=0, out_product=0, mc_bits=0, mb_bit=0, busy=1.
//  - All outputs are registered.
//    - mc_bits and mb_bit are updated on the clock edge ending the previous cycle.
//    - They are therefore stable for the whole cycle in which the core consumes them.
//  - States: INIT, IDLE, RUN, DONE.
//  - INIT
//    - Drives mb_bit=0 and mc_bits=0 for INIT_CYCLES cycles.
//    - Then moves to IDLE.
//    - Applies to any reset, including a reset asserted mid-RUN; the core state is then unknown.
//  - IDLE
//    - in_ready=1; mb_bit=0; mc_bits=0.
//    - On in_valid & in_ready: latch a and b, set count=0, go to RUN.
//  - RUN: exactly 2*WIDTH = 32 cycles, count 0..31.
//    - mc_bits = a, held for all 32 cycles.
//    - mb_bit = b[count] for count<16; mb_bit = 0 for count>=16 (flush phase).
//    - Each cycle: product[count] <= prod_bit, sampled in the cycle whose mb_bit was b[count].
//    - After count 31: go to DONE, out_valid=1, out_product = collected product.
//  - DONE
//    - out_valid=1; out_product stable; mb_bit=0; mc_bits=0.
//    - The core stays zero-state because the flush leaves it clear.
//    - On out_ready: out_valid drops next cycle, go to IDLE.
//  - Latency
//    - Accept at edge T; RUN occupies cycles T+1..T+32.
//    - out_valid rises at edge T+33.
//    - Earliest next accept is 2 cycles after the product handshake.
//  - Boundaries
//    - in_valid outside IDLE is ignored and not stored.
//    - out_ready outside DONE is ignored.
//    - in_a/in_b changing during RUN has no effect.
//    - count never wraps; the RUN->DONE transition is at count==31.
//    - Holding out_valid with out_ready low is unbounded; no product is dropped.
// TESTING
//  - Reset, then release -> in_ready=0 and mb_bit=0 for 32 cycles; in_ready=1 from cycle 33.
//  - a=3, b=5 -> out_product=0x0000000F, out_valid 33 cycles after accept.
//  - a=0xFFFF, b=0xFFFF -> 0xFFFE0001.
//    - Then a=0x0000, b=0xFFFF -> 0x00000000, proving the flush leaves no residue.
//  - a=0x1234, b=0x5678 with out_ready=0 for 10 cycles in DONE.
//    - out_product holds 0x06260060 throughout; in_ready stays 0.
//    - A new in_valid during DONE is ignored.
//  - Reset asserted at RUN count 7 -> outputs clear immediately and a full 32-cycle INIT re-runs.
//    - Then a=0x1234, b=0x5678 -> 0x06260060.
//  - Use a bit-accurate model of the core, with random initial state, across 1000 random operand pairs.
//    - Every product equals a*b.

Source files
------------

// File: rtl/mult16_serial_ctrl_if.sv
// mult16_serial_ctrl_if: operand and product handshake bundle for the serial multiplier controller.
interface mult16_serial_ctrl_if #(parameter int WIDTH = 16);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_product;
    logic                 busy;
    modport master(output in_valid, in_a, in_b, out_ready, input in_ready, out_valid, out_product, busy);
    modport slave(input in_valid, in_a, in_b, out_ready, output in_ready, out_valid, out_product, busy);
endinterface

// File: rtl/mult16_serial_ctrl.sv
// mult16_serial_ctrl: feeds a 16-bit serial shift-add multiplier core, collects its LSB-first product
// and zero-flushes the core after reset since the core itself has no reset.
module mult16_serial_ctrl #(
    parameter int WIDTH       = 16,
    parameter int INIT_CYCLES = 32
) (
    input  logic             clock,
    input  logic             reset,
    mult16_serial_ctrl_if.slave bus,
    output logic [WIDTH-1:0] mc_bits,
    output logic             mb_bit,
    input  logic             prod_bit
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(INIT_CYCLES > PW ? INIT_CYCLES : PW);
    typedef enum logic [1:0] {INIT, IDLE, RUN, DONE} state_t;
    state_t          state, nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [WIDTH-1:0] a_r, b_sh;
    logic [PW-1:0]   sr;
    logic            run_q, fire, take;
    assign fire = bus.in_valid & bus.in_ready;
    assign take = bus.out_valid & bus.out_ready;
    always_comb begin
        nxt       = state;
        count_nxt = count + 1'b1;
        case (state)
            INIT: if (count == CW'(INIT_CYCLES - 1)) begin
                nxt       = IDLE;
                count_nxt = '0;
            end
            IDLE: begin
                count_nxt = '0;
                nxt       = fire ? RUN : IDLE;
            end
            RUN: if (count == CW'(PW - 1)) begin
                nxt       = DONE;
                count_nxt = '0;
            end
            DONE: begin
                count_nxt = '0;
                nxt       = take ? IDLE : DONE;
            end
            default: nxt = INIT;
        endcase
    end
    // Core inputs lag the state by one edge, so prod_bit is sampled one edge after run_q rises
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= INIT;
            count           <= '0;
            bus.in_ready    <= 1'b0;
            bus.out_valid   <= 1'b0;
            bus.out_product <= '0;
            bus.busy        <= 1'b1;
            mc_bits         <= '0;
            mb_bit          <= 1'b0;
            run_q           <= 1'b0;
            a_r             <= '0;
            b_sh            <= '0;
            sr              <= '0;
        end else begin
            state        <= nxt;
            count        <= count_nxt;
            bus.in_ready <= nxt == IDLE;
            bus.busy     <= nxt == INIT || nxt == RUN;
            run_q        <= state == RUN;
            mc_bits      <= state == RUN ? a_r : '0;
            mb_bit       <= state == RUN && b_sh[0];
            if (fire) begin
                a_r  <= bus.in_a;
                b_sh <= bus.in_b;
            end else if (state == RUN) begin
                b_sh <= b_sh >> 1;
            end
            if (run_q)
                sr <= {prod_bit, sr[PW-1:1]};
            if (run_q && state == DONE) begin
                bus.out_product <= {prod_bit, sr[PW-1:1]};
                bus.out_valid   <= 1'b1;
            end else if (take) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule
